// File: rtl/fetch_byte_queue_if.sv
// Handshake and data bundle between the line fetcher, the byte queue and the
// instruction decoder. The queue is the slave; the fetcher/decoder side is the master.
interface fetch_byte_queue_if #(
  parameter int LINE_BYTES   = 16,
  parameter int DEPTH        = 4,
  parameter int WINDOW_BYTES = 32,
  parameter int MAX_CONSUME  = 15
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH * LINE_BYTES + 1);
  localparam int RW = $clog2(MAX_CONSUME + 1);

  logic                      flush;
  logic                      load;
  logic [OW-1:0]             load_offset;
  logic                      valid_i;
  logic                      ready_i;
  logic [8*LINE_BYTES-1:0]   data_i;
  logic                      valid_o;
  logic                      ready_o;
  logic [RW-1:0]             bytes_read_o;
  logic [CW-1:0]             valid_bytes_o;
  logic [8*WINDOW_BYTES-1:0] instruction_o;
  logic [IW:0]               occupancy_o;
  logic                      overrun_o;

  modport master (
    output flush, load, load_offset, valid_i, data_i, ready_o, bytes_read_o,
    input  ready_i, valid_o, valid_bytes_o, instruction_o, occupancy_o, overrun_o
  );

  modport slave (
    input  flush, load, load_offset, valid_i, data_i, ready_o, bytes_read_o,
    output ready_i, valid_o, valid_bytes_o, instruction_o, occupancy_o, overrun_o
  );
endinterface

// File: rtl/fetch_byte_queue.sv
// Instruction byte queue: stores DEPTH fetched lines and presents a byte-aligned
// window starting at the head byte. The decoder consumes a variable number of
// bytes per cycle; flush with load redirects the head into the next written line.
module fetch_byte_queue #(
  parameter int LINE_BYTES   = 16,
  parameter int DEPTH        = 4,
  parameter int WINDOW_BYTES = 32,
  parameter int MAX_CONSUME  = 15
) (
  input  logic               clk,
  input  logic               reset,
  fetch_byte_queue_if.slave  bus
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH * LINE_BYTES + 1);
  localparam int HW = IW + OW;
  localparam int LB = 8 * LINE_BYTES;
  localparam int WB = 8 * WINDOW_BYTES;

  logic [LB-1:0]    line_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IW-1:0]    tail_q, tail_d;
  logic [HW-1:0]    head_q, head_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OW-1:0]    skip_q, skip_d;
  logic             overrun_q, overrun_d;

  logic [IW-1:0]    head_entry;
  logic [IW-1:0]    next_entry;
  logic [OW-1:0]    head_off;
  logic             push;
  logic             consume;
  logic             pop;
  logic             ovr_hit;
  logic             line_done;
  logic [CW-1:0]    rd_cnt;
  logic [CW-1:0]    add_cnt;
  logic [CW-1:0]    sub_cnt;
  logic [OW:0]      off_sum;
  logic [2*LB-1:0]  pair;
  logic [2*LB-1:0]  shifted;
  logic [WB-1:0]    win;
  logic [IW:0]      occ;

  assign head_entry = head_q[HW-1:OW];
  assign head_off   = head_q[OW-1:0];
  assign next_entry = head_entry + IW'(1);

  // ready_i comes from registered valid bits only, so a pop never frees a slot
  // for a push in the same cycle; flush blocks acceptance combinationally.
  assign bus.ready_i = ~bus.flush & ~(&vld_q);
  assign push        = bus.valid_i & bus.ready_i;

  assign rd_cnt  = CW'(bus.bytes_read_o);
  assign consume = bus.ready_o & bus.valid_o & ~bus.flush;
  assign pop     = consume & (rd_cnt <= count_q);
  assign ovr_hit = consume & (rd_cnt > count_q);

  // A consume never spans more than one line boundary, so reaching the line
  // size from the current offset frees exactly the head entry.
  assign off_sum   = {1'b0, head_off} + (OW+1)'(bus.bytes_read_o);
  assign line_done = off_sum >= (OW+1)'(LINE_BYTES);

  assign add_cnt = push ? (CW'(LINE_BYTES) - CW'(skip_q)) : '0;
  assign sub_cnt = pop ? rd_cnt : '0;

  // Next-state for pointers, valid bits, byte count and sticky overrun; flush wins.
  always_comb begin
    vld_d     = vld_q;
    tail_d    = tail_q;
    head_d    = head_q;
    count_d   = count_q;
    skip_d    = skip_q;
    overrun_d = overrun_q;
    if (bus.flush) begin
      vld_d     = '0;
      tail_d    = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      if (bus.load) begin
        head_d = {{IW{1'b0}}, bus.load_offset};
        skip_d = bus.load_offset;
      end else begin
        head_d = '0;
        skip_d = '0;
      end
    end else begin
      if (pop) begin
        head_d = head_q + HW'(bus.bytes_read_o);
        if (line_done) vld_d[head_entry] = 1'b0;
      end
      if (ovr_hit) overrun_d = 1'b1;
      if (push) begin
        vld_d[tail_q] = 1'b1;
        tail_d        = tail_q + IW'(1);
        skip_d        = '0;
      end
      count_d = count_q + add_cnt - sub_cnt;
    end
  end

  // Control state register; reset clears every pointer and flag asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      tail_q    <= '0;
      head_q    <= '0;
      count_q   <= '0;
      skip_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      tail_q    <= tail_d;
      head_q    <= head_d;
      count_q   <= count_d;
      skip_q    <= skip_d;
      overrun_q <= overrun_d;
    end
  end

  // Line storage needs no reset: stale bytes are always hidden by the count mask.
  always_ff @(posedge clk) begin
    if (push) line_q[tail_q] <= bus.data_i;
  end

  // Window: head line low, following line high, shifted down by the head offset.
  assign pair    = {line_q[next_entry], line_q[head_entry]};
  assign shifted = pair >> {head_off, 3'b000};

  // Zero every window byte at or beyond the valid count; data paths are unmasked.
  always_comb begin
    win = '0;
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      if (CW'(k) < count_q) win[8*k +: 8] = shifted[8*k +: 8];
    end
  end

  // Occupancy is the number of line entries holding unconsumed bytes.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + (IW+1)'(vld_q[i]);
  end

  assign bus.valid_o       = (count_q != '0);
  assign bus.valid_bytes_o = count_q;
  assign bus.instruction_o = win;
  assign bus.occupancy_o   = occ;
  assign bus.overrun_o     = overrun_q;
endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: a byte-stream reference model predicts the state
// after every clock; a separate monitor compares the DUT against those predictions.
module tb_fetch_byte_queue;
  localparam int LINE_BYTES   = 16;
  localparam int DEPTH        = 4;
  localparam int WINDOW_BYTES = 32;
  localparam int MAX_CONSUME  = 15;
  localparam int OW = $clog2(LINE_BYTES);
  localparam int RW = $clog2(MAX_CONSUME + 1);
  localparam int LB = 8 * LINE_BYTES;
  localparam int WB = 8 * WINDOW_BYTES;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_byte_queue_if #(.LINE_BYTES(LINE_BYTES), .DEPTH(DEPTH),
                        .WINDOW_BYTES(WINDOW_BYTES), .MAX_CONSUME(MAX_CONSUME)) bus();

  fetch_byte_queue #(.LINE_BYTES(LINE_BYTES), .DEPTH(DEPTH),
                     .WINDOW_BYTES(WINDOW_BYTES), .MAX_CONSUME(MAX_CONSUME)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int            vb;
    int            occ;
    bit            ovr;
    bit            rdy;
    logic [WB-1:0] win;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   errors;

  // Reference model: the queued byte stream; bit 8 marks the last byte of a line.
  logic [8:0] mq[$];
  int         m_skip;
  bit         m_ovr;

  function automatic int m_occ();
    int n = 0;
    foreach (mq[i]) if (mq[i][8]) n++;
    return n;
  endfunction

  // The window covers at most the head line and the line after it.
  function automatic logic [WB-1:0] m_win();
    logic [WB-1:0] w = '0;
    int eols = 0;
    for (int k = 0; k < WINDOW_BYTES && k < mq.size(); k++) begin
      if (eols >= 2) break;
      w[8*k +: 8] = mq[k][7:0];
      if (mq[k][8]) eols++;
    end
    return w;
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] d;
    for (int i = 0; i < LB/32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_win(string nm, logic [WB-1:0] act, logic [WB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the model advances on the edge and queues its prediction.
  task automatic step(input bit fl, input bit ld, input int lo, input bit vi,
                      input logic [LB-1:0] d, input bit ro, input int n);
    bit   mrdy;
    exp_t e;
    @(negedge clk);
    bus.flush        = fl;
    bus.load         = ld;
    bus.load_offset  = OW'(lo);
    bus.valid_i      = vi;
    bus.data_i       = d;
    bus.ready_o      = ro;
    bus.bytes_read_o = RW'(n);
    mrdy = !fl && (m_occ() < DEPTH);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_ovr  = 1'b0;
      m_skip = ld ? lo : 0;
    end else begin
      if (ro && mq.size() > 0) begin
        if (n <= mq.size()) repeat (n) void'(mq.pop_front());
        else m_ovr = 1'b1;
      end
      if (vi && mrdy) begin
        for (int b = m_skip; b < LINE_BYTES; b++)
          mq.push_back({(b == LINE_BYTES-1), d[8*b +: 8]});
        m_skip = 0;
      end
    end
    e.vb  = mq.size();
    e.occ = m_occ();
    e.ovr = m_ovr;
    e.rdy = !fl && (m_occ() < DEPTH);
    e.win = m_win();
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, " valid_o"},       bus.valid_o, 0);
    chk({tag, " valid_bytes_o"}, bus.valid_bytes_o, 0);
    chk({tag, " ready_i"},       bus.ready_i, 1);
    chk({tag, " occupancy_o"},   bus.occupancy_o, 0);
    chk({tag, " overrun_o"},     bus.overrun_o, 0);
    chk_win({tag, " instruction_o"}, bus.instruction_o, '0);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_bytes_o", bus.valid_bytes_o, e.vb);
        chk("valid_o",       bus.valid_o, (e.vb != 0));
        chk("occupancy_o",   bus.occupancy_o, e.occ);
        chk("overrun_o",     bus.overrun_o, e.ovr);
        chk("ready_i",       bus.ready_i, e.rdy);
        chk_win("instruction_o", bus.instruction_o, e.win);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [LB-1:0] d;
    vectors = 0;
    errors  = 0;
    m_skip  = 0;
    m_ovr   = 1'b0;
    bus.flush = 0; bus.load = 0; bus.load_offset = '0; bus.valid_i = 0;
    bus.data_i = '0; bus.ready_o = 0; bus.bytes_read_o = '0;
    reset = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Fill: four lines holding bytes 0x00..0x3F, then an offered fifth line is refused.
    for (int l = 0; l < DEPTH; l++) begin
      for (int b = 0; b < LINE_BYTES; b++) d[8*b +: 8] = 8'(l*LINE_BYTES + b);
      step(0, 0, 0, 1, d, 0, 0);
    end
    step(0, 0, 0, 1, rand_line(), 0, 0);

    // Pop 7 then 10 from full; the second pop frees entry 0.
    step(0, 0, 0, 0, '0, 1, 7);
    step(0, 0, 0, 0, '0, 1, 10);
    idle();

    // Simultaneous push and pop.
    step(1, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 1, rand_line(), 0, 0);
    step(0, 0, 0, 1, rand_line(), 1, 5);

    // Redirect to offset 5, then push 0xA0..0xAF.
    step(1, 1, 5, 0, '0, 0, 0);
    for (int b = 0; b < LINE_BYTES; b++) d[8*b +: 8] = 8'(8'hA0 + b);
    step(0, 0, 0, 1, d, 0, 0);
    idle();

    // Consume on an empty queue is ignored.
    step(1, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 1, 9);

    // Overrun: 3 valid bytes, request 4; sticky until the next flush.
    step(1, 1, 13, 0, '0, 0, 0);
    step(0, 0, 0, 1, rand_line(), 0, 0);
    step(0, 0, 0, 0, '0, 1, 4);
    idle();
    step(0, 0, 0, 0, '0, 1, 2);
    step(1, 0, 0, 0, '0, 0, 0);

    // Wrap: push every cycle while consuming with ready_o held.
    step(0, 0, 0, 1, rand_line(), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, rand_line(), 1, (i % 2) ? 15 : 14);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, '0, 1, 15);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 25) == 0, $urandom % 2, $urandom_range(0, LINE_BYTES-1),
           ($urandom % 4) != 0, rand_line(), $urandom % 2, $urandom_range(0, MAX_CONSUME));
    end

    // Reset mid-operation while two lines are held.
    step(1, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 1, rand_line(), 0, 0);
    step(0, 0, 0, 1, rand_line(), 0, 0);
    idle();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mq.delete();
    m_skip = 0;
    m_ovr  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    step(0, 0, 0, 1, rand_line(), 1, 3);
    step(0, 0, 0, 1, rand_line(), 1, 6);
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("pending_predictions", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
